// File: rtl/sdio_card_cmd.sv
// sdio_card_cmd
//   Card-side SD/SDIO CMD line engine, clocked entirely by ctrl_clk.
//   sdio_clk is treated as sampled data. The line is read on its rising
//   edges and driven on its falling edges.
//   Receives 48-bit host command frames and checks their CRC7 and end bit.
//   Transmits 48-bit responses NCR sdio_clk falls after a request is accepted.
//
// Ports
//   ctrl_clk, rst            : system clock, synchronous active-high reset
//   sdio_clk                 : host SD clock (sampled)
//   sdio_cmd_i               : CMD line input
//   sdio_cmd_o, sdio_cmd_oen : CMD line drive value / drive enable (1 = drive)
//   o_cmd_de                 : one-cycle pulse, frame received
//   o_cmd, o_arg, o_err      : index, argument and error flag of the last frame
//   i_rsp_en, i_rsp_cmd,
//   i_rsp_arg, i_rsp_nocrc   : response request and its fields
//   o_rsp_busy, o_rsp_done   : response pending/in flight, completion pulse
module sdio_card_cmd #(
    parameter int unsigned NCR = 2
) (
    input  logic        ctrl_clk,
    input  logic        rst,
    input  logic        sdio_clk,
    input  logic        sdio_cmd_i,
    output logic        sdio_cmd_o,
    output logic        sdio_cmd_oen,
    output logic        o_cmd_de,
    output logic [5:0]  o_cmd,
    output logic [31:0] o_arg,
    output logic        o_err,
    input  logic        i_rsp_en,
    input  logic [5:0]  i_rsp_cmd,
    input  logic [31:0] i_rsp_arg,
    input  logic        i_rsp_nocrc,
    output logic        o_rsp_busy,
    output logic        o_rsp_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_NCR_WAIT,
        S_TX,
        S_RELEASE
    } state_t;

    localparam logic [6:0] NCR_LAST = 7'(NCR - 1);

    state_t       state_q, state_d;
    logic         sclk_q, sclk_d;
    logic [5:0]   bit_cnt_q, bit_cnt_d;
    logic [6:0]   ncr_cnt_q, ncr_cnt_d;
    logic [6:0]   crc_q, crc_d;
    logic [44:0]  rx_sr_q, rx_sr_d;
    logic [39:0]  tx_sr_q, tx_sr_d;
    logic         nocrc_q, nocrc_d;
    logic         cmd_o_q, cmd_o_d;
    logic         oen_q, oen_d;
    logic         cmd_de_q, cmd_de_d;
    logic [5:0]   cmd_q, cmd_d;
    logic [31:0]  arg_q, arg_d;
    logic         err_q, err_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic rise, fall;

    assign rise = sdio_clk & ~sclk_q;
    assign fall = ~sdio_clk & sclk_q;

    // CRC7, generator x^7 + x^3 + 1, one bit per call
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    always_comb begin
        state_d   = state_q;
        sclk_d    = sdio_clk;
        bit_cnt_d = bit_cnt_q;
        ncr_cnt_d = ncr_cnt_q;
        crc_d     = crc_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        nocrc_d   = nocrc_q;
        cmd_o_d   = cmd_o_q;
        oen_d     = oen_q;
        cmd_de_d  = 1'b0;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A response request takes priority over a start bit seen in the same cycle
                if (i_rsp_en) begin
                    tx_sr_d   = {2'b00, i_rsp_cmd, i_rsp_arg};
                    nocrc_d   = i_rsp_nocrc;
                    busy_d    = 1'b1;
                    ncr_cnt_d = '0;
                    crc_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_NCR_WAIT;
                end else if (rise && !sdio_cmd_i) begin
                    // The start bit is 0, so the CRC stays at its zero initial value
                    bit_cnt_d = '0;
                    crc_d     = '0;
                    state_d   = S_RX;
                end
            end

            S_RX: begin
                if (rise) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd0 && !sdio_cmd_i) begin
                        state_d = S_IDLE;
                    end else if (bit_cnt_q == 6'd46) begin
                        // The transmission bit has already been shifted out of the top of rx_sr
                        cmd_de_d = 1'b1;
                        cmd_d    = rx_sr_q[44:39];
                        arg_d    = rx_sr_q[38:7];
                        err_d    = (rx_sr_q[6:0] != crc_q) || !sdio_cmd_i;
                        state_d  = S_IDLE;
                    end else begin
                        rx_sr_d = {rx_sr_q[43:0], sdio_cmd_i};
                        if (bit_cnt_q < 6'd39) begin
                            crc_d = crc7_step(crc_q, sdio_cmd_i);
                        end
                    end
                end
            end

            S_NCR_WAIT: begin
                if (fall) begin
                    if (ncr_cnt_q == NCR_LAST) begin
                        oen_d     = 1'b1;
                        cmd_o_d   = tx_sr_q[39];
                        crc_d     = crc7_step(crc_q, tx_sr_q[39]);
                        tx_sr_d   = {tx_sr_q[38:0], 1'b0};
                        bit_cnt_d = 6'd1;
                        state_d   = S_TX;
                    end else begin
                        ncr_cnt_d = ncr_cnt_q + 7'd1;
                    end
                end
            end

            S_TX: begin
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q < 6'd40) begin
                        cmd_o_d = tx_sr_q[39];
                        crc_d   = crc7_step(crc_q, tx_sr_q[39]);
                        tx_sr_d = {tx_sr_q[38:0], 1'b0};
                    end else if (bit_cnt_q < 6'd47) begin
                        // The CRC register is shifted out MSB first
                        cmd_o_d = nocrc_q ? 1'b1 : crc_q[6];
                        crc_d   = {crc_q[5:0], 1'b0};
                    end else begin
                        cmd_o_d = 1'b1;
                        state_d = S_RELEASE;
                    end
                end
            end

            S_RELEASE: begin
                if (fall) begin
                    oen_d   = 1'b0;
                    cmd_o_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ctrl_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            ncr_cnt_q <= '0;
            crc_q     <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            nocrc_q   <= 1'b0;
            cmd_o_q   <= 1'b1;
            oen_q     <= 1'b0;
            cmd_de_q  <= 1'b0;
            cmd_q     <= '0;
            arg_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            bit_cnt_q <= bit_cnt_d;
            ncr_cnt_q <= ncr_cnt_d;
            crc_q     <= crc_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            nocrc_q   <= nocrc_d;
            cmd_o_q   <= cmd_o_d;
            oen_q     <= oen_d;
            cmd_de_q  <= cmd_de_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sdio_cmd_o   = cmd_o_q;
    assign sdio_cmd_oen = oen_q;
    assign o_cmd_de     = cmd_de_q;
    assign o_cmd        = cmd_q;
    assign o_arg        = arg_q;
    assign o_err        = err_q;
    assign o_rsp_busy   = busy_q;
    assign o_rsp_done   = done_q;

endmodule

// File: tb/tb_sdio_card_cmd.sv
// tb_sdio_card_cmd
//   Self-checking bench for sdio_card_cmd: a fixed table of host frames,
//   randomized frames and responses compared against a frame/CRC reference
//   model, plus hand-written sequences for the multi-cycle corner cases.
module tb_sdio_card_cmd;

    localparam int unsigned NCR_TB = 2;

    logic        ctrl_clk    = 1'b0;
    logic        sdio_clk    = 1'b0;
    logic        rst         = 1'b1;
    logic        sdio_cmd_i  = 1'b1;
    logic        i_rsp_en    = 1'b0;
    logic [5:0]  i_rsp_cmd   = '0;
    logic [31:0] i_rsp_arg   = '0;
    logic        i_rsp_nocrc = 1'b0;
    logic        sdio_cmd_o, sdio_cmd_oen, o_cmd_de, o_err, o_rsp_busy, o_rsp_done;
    logic [5:0]  o_cmd;
    logic [31:0] o_arg;

    sdio_card_cmd #(.NCR(NCR_TB)) dut (
        .ctrl_clk    (ctrl_clk),
        .rst         (rst),
        .sdio_clk    (sdio_clk),
        .sdio_cmd_i  (sdio_cmd_i),
        .sdio_cmd_o  (sdio_cmd_o),
        .sdio_cmd_oen(sdio_cmd_oen),
        .o_cmd_de    (o_cmd_de),
        .o_cmd       (o_cmd),
        .o_arg       (o_arg),
        .o_err       (o_err),
        .i_rsp_en    (i_rsp_en),
        .i_rsp_cmd   (i_rsp_cmd),
        .i_rsp_arg   (i_rsp_arg),
        .i_rsp_nocrc (i_rsp_nocrc),
        .o_rsp_busy  (o_rsp_busy),
        .o_rsp_done  (o_rsp_done)
    );

    // ctrl_clk period 10, sdio_clk period 80; sdio edges fall on ctrl negedges
    always #5 ctrl_clk = ~ctrl_clk;
    always #40 sdio_clk = ~sdio_clk;

    // ---------------- monitors ----------------
    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic        err;
    } rx_rec_t;

    rx_rec_t rx_q[$];
    logic    tx_q[$];
    int      done_cnt      = 0;
    int      fall_total    = 0;
    int      oen_rise_fall = -100;
    logic    oen_prev      = 1'b0;

    always @(posedge ctrl_clk) begin
        #1;
        if (o_cmd_de) rx_q.push_back('{o_cmd, o_arg, o_err});
        if (o_rsp_done) done_cnt++;
    end

    always @(negedge sdio_clk) fall_total++;

    // The host reads the card's drive on sdio_clk rising edges
    always @(posedge sdio_clk) begin
        if (sdio_cmd_oen) begin
            tx_q.push_back(sdio_cmd_o);
            if (!oen_prev) oen_rise_fall = fall_total;
        end
        oen_prev = sdio_cmd_oen;
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [46:0] m;
        m = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        end
        return m[6:0];
    endfunction

    function automatic logic [47:0] exp_rsp(input logic [5:0] cmd, input logic [31:0] arg,
                                            input logic nocrc);
        logic [6:0] c;
        c = nocrc ? 7'h7F : ref_crc7({2'b00, cmd, arg});
        return {2'b00, cmd, arg, c, 1'b1};
    endfunction

    // ---------------- host side ----------------
    typedef struct {
        logic        tbit;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic        eb;
        logic        exp_de;
        logic [5:0]  exp_cmd;
        logic [31:0] exp_arg;
        logic        exp_err;
    } vec_t;

    task automatic host_send(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sdio_clk);
            sdio_cmd_i = f[i];
        end
        @(negedge sdio_clk);
        sdio_cmd_i = 1'b1;
    endtask

    task automatic run_frame(input vec_t v, input string name);
        int base;
        base = rx_q.size();
        host_send({1'b0, v.tbit, v.idx, v.arg, v.crc, v.eb});
        repeat (2) @(negedge sdio_clk);
        check({name, "_de_cnt"}, rx_q.size() - base, v.exp_de);
        if (rx_q.size() > base) begin
            check({name, "_cmd"}, rx_q[base].cmd, v.exp_cmd);
            check({name, "_arg"}, rx_q[base].arg, v.exp_arg);
            check({name, "_err"}, rx_q[base].err, v.exp_err);
        end
        check({name, "_o_cmd_hold"}, o_cmd, v.exp_cmd);
        check({name, "_o_arg_hold"}, o_arg, v.exp_arg);
    endtask

    task automatic wait_rsp(input int tx_base, input int done_base, input int fall_base,
                            input logic [47:0] exp, input bit disturb, input string name);
        bit          seen;
        logic [47:0] got;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge ctrl_clk);
            // A second request during the response must be ignored
            if (disturb && k == 150) begin
                i_rsp_en    = 1'b1;
                i_rsp_cmd   = 6'h15;
                i_rsp_arg   = 32'hDEADBEEF;
                i_rsp_nocrc = 1'b1;
            end
            if (disturb && k == 151) i_rsp_en = 1'b0;
            if (done_cnt != done_base) begin
                seen = 1'b1;
                break;
            end
        end
        i_rsp_en = 1'b0;
        check({name, "_done_seen"}, seen, 1);
        repeat (4) @(negedge ctrl_clk);
        check({name, "_done_pulses"}, done_cnt - done_base, 1);
        check({name, "_busy_after"}, o_rsp_busy, 0);
        check({name, "_oen_after"}, sdio_cmd_oen, 0);
        check({name, "_cmd_o_after"}, sdio_cmd_o, 1);
        check({name, "_ncr_falls"}, oen_rise_fall - fall_base, NCR_TB);
        check({name, "_nbits"}, tx_q.size() - tx_base, 48);
        got = 'x;
        for (int i = 0; i < 48 && tx_base + i < tx_q.size(); i++) got[47 - i] = tx_q[tx_base + i];
        check({name, "_bits"}, got, exp);
    endtask

    task automatic run_rsp(input logic [5:0] cmd, input logic [31:0] arg, input logic nocrc,
                           input bit disturb, input string name);
        int tx_base, done_base, fall_base;
        @(posedge sdio_clk);
        @(negedge ctrl_clk);
        tx_base   = tx_q.size();
        done_base = done_cnt;
        fall_base = fall_total;
        i_rsp_cmd   = cmd;
        i_rsp_arg   = arg;
        i_rsp_nocrc = nocrc;
        i_rsp_en    = 1'b1;
        @(negedge ctrl_clk);
        i_rsp_en    = 1'b0;
        i_rsp_cmd   = ~cmd;
        i_rsp_arg   = ~arg;
        i_rsp_nocrc = ~nocrc;
        check({name, "_busy"}, o_rsp_busy, 1);
        wait_rsp(tx_base, done_base, fall_base, exp_rsp(cmd, arg, nocrc), disturb, name);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 6'd0,  32'h0000_0000, 7'h4A, 1'b1, 1'b1, 6'd0,  32'h0000_0000, 1'b0};
        vecs[1] = '{1'b1, 6'd0,  32'h0000_0000, 7'h4A, 1'b0, 1'b1, 6'd0,  32'h0000_0000, 1'b1};
        vecs[2] = '{1'b1, 6'd8,  32'h0000_01AA, 7'h43, 1'b1, 1'b1, 6'd8,  32'h0000_01AA, 1'b0};
        vecs[3] = '{1'b1, 6'd8,  32'h0000_01AA, 7'h42, 1'b1, 1'b1, 6'd8,  32'h0000_01AA, 1'b1};
        vecs[4] = '{1'b0, 6'h3F, 32'hFFFF_FFFF, 7'h7F, 1'b1, 1'b0, 6'd8,  32'h0000_01AA, 1'b0};
        vecs[5] = '{1'b1, 6'd55, 32'h0000_0000, 7'h32, 1'b1, 1'b1, 6'd55, 32'h0000_0000, 1'b0};

        rst = 1'b1;
        repeat (4) @(negedge ctrl_clk);
        check("rst_oen",   sdio_cmd_oen, 0);
        check("rst_cmd_o", sdio_cmd_o, 1);
        check("rst_de",    o_cmd_de, 0);
        check("rst_cmd",   o_cmd, 0);
        check("rst_arg",   o_arg, 0);
        check("rst_err",   o_err, 0);
        check("rst_busy",  o_rsp_busy, 0);
        check("rst_done",  o_rsp_done, 0);
        rst = 1'b0;
        repeat (2) @(negedge sdio_clk);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 10; i++) begin
            vec_t       v;
            logic [6:0] good;
            v.tbit = 1'b1;
            v.idx  = 6'($urandom);
            v.arg  = $urandom;
            good   = ref_crc7({1'b0, 1'b1, v.idx, v.arg});
            v.crc  = ($urandom_range(0, 1) == 1) ? good : 7'($urandom);
            v.eb   = ($urandom_range(0, 3) != 0);
            v.exp_de  = 1'b1;
            v.exp_cmd = v.idx;
            v.exp_arg = v.arg;
            v.exp_err = (v.crc != good) || !v.eb;
            run_frame(v, $sformatf("rnd_frame%0d", i));
        end

        run_rsp(6'd8, 32'h0000_01AA, 1'b0, 1'b1, "rsp_cmd8");
        run_rsp(6'h3F, 32'h80FF_8000, 1'b1, 1'b0, "rsp_nocrc");
        for (int i = 0; i < 5; i++) begin
            run_rsp(6'($urandom), $urandom, 1'($urandom_range(0, 1)), 1'b0,
                    $sformatf("rnd_rsp%0d", i));
        end

        // Response request in the same cycle as a start-bit rise: response wins
        begin
            int rx_base, tx_base, done_base, fall_base;
            rx_base   = rx_q.size();
            tx_base   = tx_q.size();
            done_base = done_cnt;
            fall_base = 0;
            fork
                host_send({1'b0, 1'b1, 6'd8, 32'h0000_01AA, 7'h43, 1'b1});
                begin
                    @(negedge sdio_clk);
                    @(posedge sdio_clk);
                    i_rsp_cmd   = 6'h11;
                    i_rsp_arg   = 32'h1234_5678;
                    i_rsp_nocrc = 1'b0;
                    i_rsp_en    = 1'b1;
                    fall_base   = fall_total;
                    @(negedge ctrl_clk);
                    i_rsp_en    = 1'b0;
                end
            join
            wait_rsp(tx_base, done_base, fall_base, exp_rsp(6'h11, 32'h1234_5678, 1'b0),
                     1'b0, "collide");
            check("collide_no_de", rx_q.size() - rx_base, 0);
        end

        // Reset in the middle of a response
        begin
            int tx_base, done_base;
            bit reached;
            @(posedge sdio_clk);
            @(negedge ctrl_clk);
            tx_base   = tx_q.size();
            done_base = done_cnt;
            i_rsp_cmd = 6'h2A;
            i_rsp_arg = 32'hA5A5_0F0F;
            i_rsp_en  = 1'b1;
            @(negedge ctrl_clk);
            i_rsp_en  = 1'b0;
            reached   = 1'b0;
            for (int k = 0; k < 2000; k++) begin
                @(negedge ctrl_clk);
                if (tx_q.size() - tx_base >= 20) begin
                    reached = 1'b1;
                    break;
                end
            end
            check("rstmid_reached_bit20", reached, 1);
            rst = 1'b1;
            @(negedge ctrl_clk);
            check("rstmid_oen",   sdio_cmd_oen, 0);
            check("rstmid_cmd_o", sdio_cmd_o, 1);
            check("rstmid_busy",  o_rsp_busy, 0);
            check("rstmid_arg",   o_arg, 0);
            rst = 1'b0;
            repeat (80) @(negedge ctrl_clk);
            check("rstmid_no_done", done_cnt - done_base, 0);
            check("rstmid_oen_idle", sdio_cmd_oen, 0);
            run_frame(vecs[5], "post_rst_cmd55");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdio_card_cmd.md
SDIO_CARD_CMD -- requirements
Module: sdio_card_cmd

Interface
- REQ-001: Parameter NCR, default 2: sdio_clk falling edges from response acceptance to the response start bit; legal range 2..64.
- REQ-002: ctrl_clk  input  1  sole clock; all state changes on rising edge; at least 4x the sdio_clk frequency.
- REQ-003: rst  input  1  reset, synchronous, active-high.
- REQ-004: sdio_clk  input  1  host-driven SD clock, sampled as data in the ctrl_clk domain.
- REQ-005: sdio_cmd_i  input  1  CMD line value.
- REQ-006: sdio_cmd_o  output  1  CMD line drive value.
- REQ-007: sdio_cmd_oen  output  1  CMD drive enable; 1 means the block drives the line.
- REQ-008: o_cmd_de  output  1  one-cycle pulse: command frame received.
- REQ-009: o_cmd  output  6  received command index.
- REQ-010: o_arg  output  32  received argument.
- REQ-011: o_err  output  1  received frame had a CRC7 mismatch or end bit 0; valid with o_cmd_de.
- REQ-012: i_rsp_en  input  1  request to send a 48-bit response.
- REQ-013: i_rsp_cmd  input  6  response index field.
- REQ-014: i_rsp_arg  input  32  response argument field.
- REQ-015: i_rsp_nocrc  input  1  CRC field is forced to 7'h7F (R3 style).
- REQ-016: o_rsp_busy  output  1  response pending or in transmission.
- REQ-017: o_rsp_done  output  1  one-cycle pulse when the response completes.

Function
- REQ-018: The block SHALL register sdio_clk once; rise = sdio_clk & ~q and fall = ~sdio_clk & q, each a single ctrl_clk cycle.
- REQ-019: The block SHALL sample sdio_cmd_i only in rise cycles and change sdio_cmd_o / sdio_cmd_oen only in fall cycles, except on reset.
- REQ-020: States SHALL be IDLE, RX, NCR_WAIT, TX and RELEASE.
- REQ-021: IDLE -> RX SHALL occur on the first rise that samples CMD=0 (start bit).
- REQ-022: RX SHALL sample 47 more bits in MSB-first order: transmission bit, index[5:0], arg[31:0], crc[6:0], end bit.
- REQ-023: If the transmission bit is 0 (a host-direction violation or another card's response), the block SHALL abort to IDLE silently with no o_cmd_de.
- REQ-024: CRC7 SHALL use polynomial x^7+x^3+1 with initial value 0, computed over the first 40 bits.
- REQ-025: One ctrl_clk after the rise that samples the end bit, the block SHALL pulse o_cmd_de for one cycle and return to IDLE.
- REQ-026: o_cmd and o_arg SHALL update at that pulse and hold until the next pulse.
- REQ-027: With that pulse, o_err SHALL be 1 if the CRC mismatches or the end bit is 0, else 0.
- REQ-028: In IDLE, i_rsp_en=1 SHALL be accepted: i_rsp_cmd, i_rsp_arg and i_rsp_nocrc latched; o_rsp_busy=1 the next cycle; state -> NCR_WAIT.
- REQ-029: i_rsp_en SHALL be ignored while o_rsp_busy=1 or while in RX.
- REQ-030: If i_rsp_en is high in the same IDLE cycle as a start-bit rise, the response SHALL win and the start bit SHALL be ignored.
- REQ-031: NCR_WAIT SHALL count fall edges; on the NCR-th fall it SHALL set sdio_cmd_oen=1, drive sdio_cmd_o=0 (start bit) and enter TX.
- REQ-032: TX SHALL drive one bit per fall in the order: transmission bit 0, index, arg, CRC field, end bit 1 (48 bits total).
- REQ-033: The CRC field SHALL be the CRC7 over the 40 transmitted header/argument bits, or 7'h7F when i_rsp_nocrc was latched.
- REQ-034: On the fall following the end bit, the block SHALL set sdio_cmd_oen=0 and sdio_cmd_o=1, pulse o_rsp_done, clear o_rsp_busy and return to IDLE.
- REQ-035: The receiver SHALL ignore the CMD line from acceptance until the return to IDLE.

Reset
- REQ-036: While rst=1 at a ctrl_clk edge, all outputs SHALL be forced to: sdio_cmd_oen=0, sdio_cmd_o=1, o_cmd_de=0, o_cmd=0, o_arg=0, o_err=0, o_rsp_busy=0, o_rsp_done=0.
- REQ-037: Reset SHALL put the state in IDLE and clear the counters, shift registers and the sdio_clk history.
- REQ-038: Reset asserted mid-RX or mid-TX SHALL release the line on the next ctrl_clk edge, with no o_cmd_de or o_rsp_done pulse.

Verification
- REQ-039: Host sends CMD0, arg 0x00000000, CRC7 0x4A, end bit 1 -> one o_cmd_de pulse; o_cmd=0, o_arg=0, o_err=0.
- REQ-040: Host sends CMD8, arg 0x000001AA, CRC7 0x43 -> o_cmd=8, o_arg=0x000001AA, o_err=0. The same frame with CRC7 0x42 -> o_err=1.
- REQ-041: i_rsp_en with cmd=8, arg=0x000001AA, nocrc=0 and NCR=2 -> oen rises at the 2nd fall; 48 bits observed on the falls: 0,0,001000,arg, CRC7 of the first 40 bits, 1; then oen=0 and a single o_rsp_done pulse.
- REQ-042: Response with nocrc=1, cmd=6'h3F, arg=0x80FF8000 -> CRC field 1111111, end bit 1.
- REQ-043: A frame with transmission bit 0 -> no o_cmd_de; a following valid CMD55, arg 0, is still received correctly.
- REQ-044: rst pulsed at bit 20 of TX -> oen=0 on the next cycle, o_rsp_busy=0, no o_rsp_done; a subsequent command is received correctly.
